// File: rtl/ahbl_slave_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ahbl_slave_arbiter_pkg
//   Shared AHB-Lite encodings for the slave-port arbiter: HTRANS, HRESP and
//   HSIZE codes, plus a helper that decides whether an HTRANS value is a real
//   transfer request.
// ---------------------------------------------------------------------------
package ahbl_slave_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  // NONSEQ and SEQ carry a transfer; IDLE and BUSY do not.
  function automatic logic htrans_is_req(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahbl_slave_arbiter_rr_arb_sel.sv
// ---------------------------------------------------------------------------
// rr_arb_sel
//   Combinational one-hot grant selector.
//   fixed = 0 : round-robin, first requester at or after ptr wins.
//   fixed = 1 : lowest requesting index wins.
// Ports
//   req  [N]          request vector
//   ptr  [clog2(N)]   round-robin start index
//   fixed             selects fixed-priority mode
//   gnt  [N]          one-hot grant (all zero when nothing requests)
// ---------------------------------------------------------------------------
module rr_arb_sel #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 fixed,
  output logic [N-1:0]         gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      // The modulo also folds an out-of-range ptr when N is not a power of two.
      idx = fixed ? i : (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahbl_slave_arbiter.sv
// ---------------------------------------------------------------------------
// ahbl_slave_arbiter
//   Shares one AHB-Lite slave port between N_MASTERS AHB-Lite masters.
//   A master that loses arbitration (or arrives while the slave is stalling)
//   has its address phase captured in a per-master buffer and is stalled via
//   its HREADYOUT until the buffered request is issued. Write data, read data
//   and responses follow the data-phase owner.
//
// Handshake: an address phase is accepted from master m on a rising edge
//   where src_hready[m]=1 and HTRANS is NONSEQ/SEQ. A master whose
//   src_hready_resp is 0 must hold its data phase (and any pending address)
//   until it sees src_hready_resp=1. Towards the slave, a transfer is issued
//   only on a cycle where dst_hready_resp=1.
//
// Ports
//   HCLK, HRESET       clock, synchronous active-high reset
//   src_hready         per-master HREADY as seen by that master
//   src_hready_resp    per-master HREADYOUT
//   src_hresp          per-master HRESP
//   src_haddr/hwrite/htrans/hsize/hwdata   master buses, master 0 in LSBs
//   src_hrdata         slave read data broadcast to every master
//   dst_hready         HREADY to slave
//   dst_hready_resp    slave HREADYOUT
//   dst_hresp          slave HRESP
//   dst_haddr/hwrite/htrans/hsize/hwdata   address/data phase to slave
//   dst_hrdata         slave read data
// ---------------------------------------------------------------------------
module ahbl_slave_arbiter
  import ahbl_slave_arbiter_pkg::*;
#(
  parameter int N_MASTERS  = 2,
  parameter int W_ADDR     = 32,
  parameter int W_DATA     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic [N_MASTERS-1:0]          src_hready,
  output logic [N_MASTERS-1:0]          src_hready_resp,
  output logic [N_MASTERS-1:0]          src_hresp,
  input  logic [N_MASTERS*W_ADDR-1:0]   src_haddr,
  input  logic [N_MASTERS-1:0]          src_hwrite,
  input  logic [N_MASTERS*2-1:0]        src_htrans,
  input  logic [N_MASTERS*3-1:0]        src_hsize,
  input  logic [N_MASTERS*W_DATA-1:0]   src_hwdata,
  output logic [N_MASTERS*W_DATA-1:0]   src_hrdata,
  output logic                          dst_hready,
  input  logic                          dst_hready_resp,
  input  logic                          dst_hresp,
  output logic [W_ADDR-1:0]             dst_haddr,
  output logic                          dst_hwrite,
  output logic [1:0]                    dst_htrans,
  output logic [2:0]                    dst_hsize,
  output logic [W_DATA-1:0]             dst_hwdata,
  input  logic [W_DATA-1:0]             dst_hrdata
);

  localparam int W_IDX = $clog2(N_MASTERS);

  // Unpacked views of the flattened master buses.
  logic [W_ADDR-1:0] s_addr  [N_MASTERS];
  logic [1:0]        s_trans [N_MASTERS];
  logic [2:0]        s_size  [N_MASTERS];
  logic [W_DATA-1:0] s_wdata [N_MASTERS];

  // Per-master address-phase buffers.
  logic [N_MASTERS-1:0] buf_valid;
  logic [W_ADDR-1:0]    buf_addr  [N_MASTERS];
  logic [N_MASTERS-1:0] buf_write;
  logic [1:0]           buf_trans [N_MASTERS];
  logic [2:0]           buf_size  [N_MASTERS];

  logic [N_MASTERS-1:0] live;
  logic [N_MASTERS-1:0] req;
  logic [N_MASTERS-1:0] gnt;
  logic [N_MASTERS-1:0] is_owner;
  logic                 issue;
  logic [W_IDX-1:0]     win_idx;
  logic [W_IDX-1:0]     rr_ptr;
  logic [W_IDX-1:0]     rr_ptr_nxt;

  logic                 dph_valid;
  logic [W_IDX-1:0]     dph_owner;

  // Last issued address-phase attributes, held on the slave bus when idle.
  logic [W_ADDR-1:0]    last_addr;
  logic                 last_write;
  logic [2:0]           last_size;

  logic [W_ADDR-1:0]    iss_addr;
  logic                 iss_write;
  logic [1:0]           iss_trans;
  logic [2:0]           iss_size;

  for (genvar m = 0; m < N_MASTERS; m++) begin : g_master
    assign s_addr[m]  = src_haddr[m*W_ADDR +: W_ADDR];
    assign s_trans[m] = src_htrans[m*2 +: 2];
    assign s_size[m]  = src_hsize[m*3 +: 3];
    assign s_wdata[m] = src_hwdata[m*W_DATA +: W_DATA];

    // A live request is ignored while the buffer is occupied.
    assign live[m]     = src_hready[m] & htrans_is_req(s_trans[m]) & ~buf_valid[m];
    assign req[m]      = live[m] | buf_valid[m];
    assign is_owner[m] = dph_valid & (int'(dph_owner) == m);

    a_no_live_when_buffered: assert property (@(posedge HCLK) disable iff (HRESET)
      !(src_hready[m] && htrans_is_req(s_trans[m]) && buf_valid[m]));
  end

  // Arbitration only happens in a cycle where the slave can accept an address.
  logic [N_MASTERS-1:0] sel_gnt;

  rr_arb_sel #(.N(N_MASTERS)) u_sel (
    .req   (req),
    .ptr   (rr_ptr),
    .fixed (FIXED_PRIO != 0),
    .gnt   (sel_gnt)
  );

  assign gnt   = dst_hready_resp ? sel_gnt : '0;
  assign issue = |gnt;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (gnt[i]) win_idx = W_IDX'(i);
    end
  end

  assign rr_ptr_nxt = (int'(win_idx) == N_MASTERS - 1) ? '0 : win_idx + W_IDX'(1);

  // The winner is driven from its buffer if one is pending, otherwise its live
  // bus passes straight through so an uncontended master sees no added latency.
  always_comb begin
    if (buf_valid[win_idx]) begin
      iss_addr  = buf_addr[win_idx];
      iss_write = buf_write[win_idx];
      iss_trans = buf_trans[win_idx];
      iss_size  = buf_size[win_idx];
    end else begin
      iss_addr  = s_addr[win_idx];
      iss_write = src_hwrite[win_idx];
      iss_trans = s_trans[win_idx];
      iss_size  = s_size[win_idx];
    end
  end

  assign dst_hready = dst_hready_resp;
  assign dst_htrans = issue ? iss_trans : HTRANS_IDLE;
  assign dst_haddr  = issue ? iss_addr  : last_addr;
  assign dst_hwrite = issue ? iss_write : last_write;
  assign dst_hsize  = issue ? iss_size  : last_size;
  assign dst_hwdata = dph_valid ? s_wdata[dph_owner] : '0;
  assign src_hrdata = {N_MASTERS{dst_hrdata}};

  // The owner sees the slave's ready/response unchanged (including both
  // cycles of an ERROR); a buffered master is stalled; everyone else is idle.
  always_comb begin
    src_hready_resp = '1;
    src_hresp       = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (is_owner[i]) begin
        src_hready_resp[i] = dst_hready_resp;
        src_hresp[i]       = dst_hresp;
      end else begin
        src_hready_resp[i] = ~buf_valid[i];
        src_hresp[i]       = HRESP_OKAY;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      buf_valid  <= '0;
      buf_write  <= '0;
      dph_valid  <= 1'b0;
      dph_owner  <= '0;
      rr_ptr     <= '0;
      last_addr  <= '0;
      last_write <= 1'b0;
      last_size  <= '0;
      for (int i = 0; i < N_MASTERS; i++) begin
        buf_addr[i]  <= '0;
        buf_trans[i] <= HTRANS_IDLE;
        buf_size[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (gnt[i]) begin
          buf_valid[i] <= 1'b0;
        end else if (live[i]) begin
          // Lost arbitration, or the slave slot was unavailable.
          buf_valid[i] <= 1'b1;
          buf_addr[i]  <= s_addr[i];
          buf_write[i] <= src_hwrite[i];
          buf_trans[i] <= s_trans[i];
          buf_size[i]  <= s_size[i];
        end
      end

      if (issue) begin
        dph_valid  <= 1'b1;
        dph_owner  <= win_idx;
        rr_ptr     <= rr_ptr_nxt;
        last_addr  <= iss_addr;
        last_write <= iss_write;
        last_size  <= iss_size;
      end else if (dst_hready_resp) begin
        dph_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ahbl_slave_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahbl_slave_arbiter
//   Directed bench for ahbl_slave_arbiter with two masters. A round-robin
//   instance carries the table-driven sequences; a fixed-priority instance
//   sharing the same stimulus is checked in the back-to-back sequence.
//   Each master's HREADY is looped back from its own HREADYOUT.
// ---------------------------------------------------------------------------
module tb_ahbl_slave_arbiter;
  import ahbl_slave_arbiter_pkg::*;

  localparam logic [1:0] NS = HTRANS_NONSEQ;
  localparam logic [1:0] ID = HTRANS_IDLE;
  localparam logic       O  = 1'b0;
  localparam logic       I  = 1'b1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic HRESET;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic [1:0]  t0, t1;
  logic [31:0] a0, a1, d0, d1, rd;
  logic        w0, w1, rdy, err;

  logic [63:0] src_haddr;
  logic [1:0]  src_hwrite;
  logic [3:0]  src_htrans;
  logic [5:0]  src_hsize;
  logic [63:0] src_hwdata;

  assign src_haddr  = {a1, a0};
  assign src_hwrite = {w1, w0};
  assign src_htrans = {t1, t0};
  assign src_hsize  = {HSIZE_WORD, HSIZE_WORD};
  assign src_hwdata = {d1, d0};

  // ---------------- round-robin instance ----------------
  logic [1:0]  rr_src_hready, rr_src_hready_resp, rr_src_hresp;
  logic [63:0] rr_src_hrdata;
  logic        rr_dst_hready, rr_dst_hwrite;
  logic [31:0] rr_dst_haddr, rr_dst_hwdata;
  logic [1:0]  rr_dst_htrans;
  logic [2:0]  rr_dst_hsize;

  assign rr_src_hready = rr_src_hready_resp;

  ahbl_slave_arbiter #(.N_MASTERS(2), .W_ADDR(32), .W_DATA(32), .FIXED_PRIO(0)) u_rr (
    .HCLK            (clk),
    .HRESET          (HRESET),
    .src_hready      (rr_src_hready),
    .src_hready_resp (rr_src_hready_resp),
    .src_hresp       (rr_src_hresp),
    .src_haddr       (src_haddr),
    .src_hwrite      (src_hwrite),
    .src_htrans      (src_htrans),
    .src_hsize       (src_hsize),
    .src_hwdata      (src_hwdata),
    .src_hrdata      (rr_src_hrdata),
    .dst_hready      (rr_dst_hready),
    .dst_hready_resp (rdy),
    .dst_hresp       (err),
    .dst_haddr       (rr_dst_haddr),
    .dst_hwrite      (rr_dst_hwrite),
    .dst_htrans      (rr_dst_htrans),
    .dst_hsize       (rr_dst_hsize),
    .dst_hwdata      (rr_dst_hwdata),
    .dst_hrdata      (rd)
  );

  // ---------------- fixed-priority instance ----------------
  logic [1:0]  fx_src_hready, fx_src_hready_resp, fx_src_hresp;
  logic [63:0] fx_src_hrdata;
  logic        fx_dst_hready, fx_dst_hwrite;
  logic [31:0] fx_dst_haddr, fx_dst_hwdata;
  logic [1:0]  fx_dst_htrans;
  logic [2:0]  fx_dst_hsize;

  assign fx_src_hready = fx_src_hready_resp;

  ahbl_slave_arbiter #(.N_MASTERS(2), .W_ADDR(32), .W_DATA(32), .FIXED_PRIO(1)) u_fx (
    .HCLK            (clk),
    .HRESET          (HRESET),
    .src_hready      (fx_src_hready),
    .src_hready_resp (fx_src_hready_resp),
    .src_hresp       (fx_src_hresp),
    .src_haddr       (src_haddr),
    .src_hwrite      (src_hwrite),
    .src_htrans      (src_htrans),
    .src_hsize       (src_hsize),
    .src_hwdata      (src_hwdata),
    .src_hrdata      (fx_src_hrdata),
    .dst_hready      (fx_dst_hready),
    .dst_hready_resp (rdy),
    .dst_hresp       (err),
    .dst_haddr       (fx_dst_haddr),
    .dst_hwrite      (fx_dst_hwrite),
    .dst_htrans      (fx_dst_htrans),
    .dst_hsize       (fx_dst_hsize),
    .dst_hwdata      (fx_dst_hwdata),
    .dst_hrdata      (rd)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic [1:0]  t0;
    logic [31:0] a0;
    logic        w0;
    logic [31:0] d0;
    logic [1:0]  t1;
    logic [31:0] a1;
    logic        w1;
    logic [31:0] d1;
    logic        rdy;
    logic        err;
    logic [31:0] rd;
    logic [1:0]  e_trans;
    logic [31:0] e_addr;
    logic        e_write;
    logic [31:0] e_wdata;
    logic [1:0]  e_rdy;
    logic [1:0]  e_resp;
  } vec_t;

  localparam int N_ROWS = 17;
  vec_t vecs [N_ROWS];

  function automatic vec_t mk(
    input logic rst,
    input logic [1:0] vt0, input logic [31:0] va0, input logic vw0, input logic [31:0] vd0,
    input logic [1:0] vt1, input logic [31:0] va1, input logic vw1, input logic [31:0] vd1,
    input logic vrdy, input logic verr, input logic [31:0] vrd,
    input logic [1:0] et, input logic [31:0] ea, input logic ew, input logic [31:0] ewd,
    input logic [1:0] erdy, input logic [1:0] eresp);
    vec_t v;
    v.rst = rst;
    v.t0 = vt0; v.a0 = va0; v.w0 = vw0; v.d0 = vd0;
    v.t1 = vt1; v.a1 = va1; v.w1 = vw1; v.d1 = vd1;
    v.rdy = vrdy; v.err = verr; v.rd = vrd;
    v.e_trans = et; v.e_addr = ea; v.e_write = ew; v.e_wdata = ewd;
    v.e_rdy = erdy; v.e_resp = eresp;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    t0 = ID; a0 = '0; w0 = O; d0 = '0;
    t1 = ID; a1 = '0; w1 = O; d1 = '0;
    rdy = I; err = O; rd = '0;
  endtask

  task automatic do_reset();
    set_idle();
    HRESET = 1'b1;
    tick();
    tick();
    HRESET = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // Reads, contention on writes, wait states, ERROR response.
    vecs[0]  = mk(O, NS, 32'h2000_2000, O, 32'h0, ID, 32'h0, O, 32'h0, I, O, 32'h0,
                  NS, 32'h2000_2000, O, 32'h0, 2'b11, 2'b00);
    vecs[1]  = mk(O, ID, 32'h0, O, 32'h0, ID, 32'h0, O, 32'h0, I, O, 32'hCAFE_0001,
                  ID, 32'h2000_2000, O, 32'h0, 2'b11, 2'b00);
    vecs[2]  = mk(O, ID, 32'h0, O, 32'h0, ID, 32'h0, O, 32'h0, I, O, 32'h0,
                  ID, 32'h2000_2000, O, 32'h0, 2'b11, 2'b00);
    vecs[3]  = mk(I, ID, 32'h0, O, 32'h0, ID, 32'h0, O, 32'h0, I, O, 32'h0,
                  ID, 32'h0, O, 32'h0, 2'b11, 2'b00);
    vecs[4]  = mk(O, NS, 32'h2000_2004, I, 32'h0, NS, 32'h2000_2008, I, 32'h0, I, O, 32'h0,
                  NS, 32'h2000_2004, I, 32'h0, 2'b11, 2'b00);
    vecs[5]  = mk(O, ID, 32'h0, O, 32'h1111_0000, ID, 32'h0, O, 32'h2222_0000, I, O, 32'h0,
                  NS, 32'h2000_2008, I, 32'h1111_0000, 2'b01, 2'b00);
    vecs[6]  = mk(O, ID, 32'h0, O, 32'h0, ID, 32'h0, O, 32'h2222_0000, I, O, 32'h0,
                  ID, 32'h2000_2008, I, 32'h2222_0000, 2'b11, 2'b00);
    vecs[7]  = mk(O, NS, 32'h2000_3000, O, 32'h0, ID, 32'h0, O, 32'h0, I, O, 32'h0,
                  NS, 32'h2000_3000, O, 32'h0, 2'b11, 2'b00);
    vecs[8]  = mk(O, ID, 32'h0, O, 32'h0, NS, 32'h2000_3100, O, 32'h0, O, O, 32'h0,
                  ID, 32'h2000_3000, O, 32'h0, 2'b10, 2'b00);
    vecs[9]  = mk(O, ID, 32'h0, O, 32'h0, NS, 32'h2000_3100, O, 32'h0, O, O, 32'h0,
                  ID, 32'h2000_3000, O, 32'h0, 2'b00, 2'b00);
    vecs[10] = mk(O, ID, 32'h0, O, 32'h0, NS, 32'h2000_3100, O, 32'h0, O, O, 32'h0,
                  ID, 32'h2000_3000, O, 32'h0, 2'b00, 2'b00);
    vecs[11] = mk(O, ID, 32'h0, O, 32'h0, NS, 32'h2000_3100, O, 32'h0, I, O, 32'hDEAD_BEEF,
                  NS, 32'h2000_3100, O, 32'h0, 2'b01, 2'b00);
    vecs[12] = mk(O, ID, 32'h0, O, 32'h0, ID, 32'h0, O, 32'h0, I, O, 32'h0000_3100,
                  ID, 32'h2000_3100, O, 32'h0, 2'b11, 2'b00);
    vecs[13] = mk(O, ID, 32'h0, O, 32'h0, NS, 32'h2000_4000, I, 32'h0, I, O, 32'h0,
                  NS, 32'h2000_4000, I, 32'h0, 2'b11, 2'b00);
    vecs[14] = mk(O, NS, 32'h2000_4100, O, 32'h0, ID, 32'h0, O, 32'h5555_0000, O, I, 32'h0,
                  ID, 32'h2000_4000, I, 32'h5555_0000, 2'b01, 2'b10);
    vecs[15] = mk(O, NS, 32'h2000_4100, O, 32'h0, ID, 32'h0, O, 32'h5555_0000, I, I, 32'h0,
                  NS, 32'h2000_4100, O, 32'h5555_0000, 2'b10, 2'b10);
    vecs[16] = mk(O, ID, 32'h0, O, 32'h0, ID, 32'h0, O, 32'h0, I, O, 32'h4100_4100,
                  ID, 32'h2000_4100, O, 32'h0, 2'b11, 2'b00);

    // Reset state.
    do_reset();
    #2;
    chk("reset dst_htrans", 64'(rr_dst_htrans), 64'(HTRANS_IDLE));
    chk("reset dst_haddr", 64'(rr_dst_haddr), 64'h0);
    chk("reset src_hready_resp", 64'(rr_src_hready_resp), 64'h3);
    chk("reset src_hresp", 64'(rr_src_hresp), 64'h0);
    chk("reset dst_hwdata", 64'(rr_dst_hwdata), 64'h0);
    tick();

    // Table-driven sequences.
    for (int i = 0; i < N_ROWS; i++) begin
      HRESET = vecs[i].rst;
      t0 = vecs[i].t0; a0 = vecs[i].a0; w0 = vecs[i].w0; d0 = vecs[i].d0;
      t1 = vecs[i].t1; a1 = vecs[i].a1; w1 = vecs[i].w1; d1 = vecs[i].d1;
      rdy = vecs[i].rdy; err = vecs[i].err; rd = vecs[i].rd;
      #2;
      if (!vecs[i].rst) begin
        chk($sformatf("v%0d dst_htrans", i), 64'(rr_dst_htrans), 64'(vecs[i].e_trans));
        chk($sformatf("v%0d dst_haddr", i), 64'(rr_dst_haddr), 64'(vecs[i].e_addr));
        chk($sformatf("v%0d dst_hwrite", i), 64'(rr_dst_hwrite), 64'(vecs[i].e_write));
        chk($sformatf("v%0d dst_hwdata", i), 64'(rr_dst_hwdata), 64'(vecs[i].e_wdata));
        chk($sformatf("v%0d src_hready_resp", i), 64'(rr_src_hready_resp), 64'(vecs[i].e_rdy));
        chk($sformatf("v%0d src_hresp", i), 64'(rr_src_hresp), 64'(vecs[i].e_resp));
        chk($sformatf("v%0d src_hrdata", i), rr_src_hrdata, {vecs[i].rd, vecs[i].rd});
        chk($sformatf("v%0d dst_hready", i), 64'(rr_dst_hready), 64'(vecs[i].rdy));
      end
      tick();
    end
    HRESET = 1'b0;

    // Back-to-back requests from both masters for 8 slots.
    do_reset();
    t0 = NS; a0 = 32'h0000_1000;
    t1 = NS; a1 = 32'h0000_2000;
    for (int i = 0; i < 8; i++) begin
      #2;
      chk($sformatf("b2b%0d rr dst_htrans", i), 64'(rr_dst_htrans), 64'(HTRANS_NONSEQ));
      chk($sformatf("b2b%0d rr dst_haddr", i), 64'(rr_dst_haddr),
          (i % 2 == 0) ? 64'h1000 : 64'h2000);
      chk($sformatf("b2b%0d fx dst_haddr", i), 64'(fx_dst_haddr), 64'h1000);
      chk($sformatf("b2b%0d rr dst_hsize", i), 64'(rr_dst_hsize), 64'(HSIZE_WORD));
      if (i > 0) begin
        chk($sformatf("b2b%0d fx src_hready_resp", i), 64'(fx_src_hready_resp), 64'h1);
      end
      tick();
    end

    // Reset while M1 is buffered.
    do_reset();
    t0 = NS; a0 = 32'h3000_0000;
    t1 = NS; a1 = 32'h3000_0100;
    #2;
    chk("rst_mid issue", 64'(rr_dst_haddr), 64'h3000_0000);
    tick();
    set_idle();
    HRESET = 1'b1;
    #2;
    chk("rst_mid buffered", 64'(rr_src_hready_resp), 64'h1);
    tick();
    HRESET = 1'b0;
    #2;
    chk("rst_mid src_hready_resp", 64'(rr_src_hready_resp), 64'h3);
    chk("rst_mid dst_htrans", 64'(rr_dst_htrans), 64'(HTRANS_IDLE));
    chk("rst_mid dst_haddr", 64'(rr_dst_haddr), 64'h0);
    chk("rst_mid src_hresp", 64'(rr_src_hresp), 64'h0);
    chk("rst_mid dst_hwdata", 64'(rr_dst_hwdata), 64'h0);
    chk("rst_mid fx src_hready_resp", 64'(fx_src_hready_resp), 64'h3);
    tick();
    #2;
    chk("rst_mid no reissue", 64'(rr_dst_htrans), 64'(HTRANS_IDLE));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
